mesi_bus_arbiter: RTL and testbench
===================================

# mesi_bus_arbiter

Snoop-bus arbiter and transaction sequencer for a cluster of MESI caches. It grants one cache's bus request at a time, round-robin, and broadcasts the transaction to every other cache as BR/BW snoop strobes. It collects the snoop responses and returns the shared indication S to the requester. It sits directly upstream of each cache's `mesi_fsm` and drives that FSM's BR, BW and S inputs.

## Interface
Parameters:
- `N_CACHES`, 4: number of caches on the bus (2..8)
- `DATA_BEATS`, 4: data-phase length in cycles (1..16)

Ports:
- `clk`  in  1  single system clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately
- `req_valid`  in  N_CACHES  per-cache bus request; held until granted
- `req_write`  in  N_CACHES  1 = BusRdX (write miss/upgrade), 0 = BusRd; sampled with request
- `req_ready`  out  N_CACHES  one-hot, one-cycle grant pulse
- `snoop_hit`  in  N_CACHES  cache holds the snooped line valid
- `snoop_dirty`  in  N_CACHES  cache holds the snooped line Modified and will flush
- `BR`  out  N_CACHES  snoop bus-read strobe to each non-owner FSM
- `BW`  out  N_CACHES  snoop bus-write strobe to each non-owner FSM
- `S`  out  N_CACHES  shared line, driven only toward the owner
- `flush_sel`  out  N_CACHES  one-hot, selects the dirty cache supplying data
- `done`  out  N_CACHES  one-cycle pulse to the owner on the last data beat
- `bus_busy`  out  1  transaction in progress
- `owner`  out  $clog2(N_CACHES)  index of the current owner
- `protocol_err`  out  1  sticky; cleared only by reset

## Operation
- States: IDLE, SNOOP, DATA.
- **IDLE**
  - If any `req_valid` is set, pick the winner round-robin, starting from the index after `last_owner`.
  - Register `owner` and `req_write[owner]`, update `last_owner`, go to SNOOP.
  - Otherwise stay in IDLE.
- **SNOOP** (exactly 1 cycle)
  - `req_ready[owner]`=1.
  - Read transaction: `BR`=1 on every index except `owner`. Write transaction: `BW`=1 on the same set instead.
  - `snoop_hit` and `snoop_dirty` are sampled from non-owners at the end of the cycle. The owner's own bits are ignored.
  - Go to DATA, beat counter = 0.
- **DATA** (`DATA_BEATS` cycles)
  - `S[owner]` = OR of the sampled non-owner hits, held constant.
  - `flush_sel` = lowest-index sampled dirty bit, or 0 if none.
  - `done[owner]`=1 on the beat where count = DATA_BEATS-1; the next state is IDLE.
- `bus_busy`=1 in SNOOP and DATA.
- Requests deasserted before grant are dropped with no effect. Requests asserted during SNOOP/DATA wait for IDLE.
- `protocol_err` is set when any of these occur:
  - More than one non-owner asserts `snoop_dirty`.
  - `req_valid[owner]` drops during SNOOP.

## Timing
- Reset values:
  - State IDLE; `last_owner` = N_CACHES-1, so cache 0 wins first.
  - All outputs 0.
- All outputs are registered, with no combinational input-to-output path.
- Request sampled in IDLE at cycle t:
  - `req_ready`/`BR`/`BW` high at t+1.
  - `S`/`flush_sel` valid at t+2 through t+1+DATA_BEATS.
  - `done` at t+1+DATA_BEATS.
  - IDLE at t+2+DATA_BEATS.
- Occupancy is DATA_BEATS+2 cycles per transaction, with a minimum of one IDLE cycle between transactions.
- Simultaneous requests are resolved strictly by round-robin order, never by index priority.
- Reset mid-transaction forces IDLE and zeroes all outputs asynchronously. No `done` is issued for the aborted transaction.
- The beat counter width is $clog2(DATA_BEATS+1). It does not wrap within a transaction.

## Structure
- Package `mesi_pkg`:
  - `bus_state_t` enum (IDLE, SNOOP, DATA).
  - MESI 2-bit state encodings shared with `mesi_fsm`.
  - `bus_op_t` (BUS_RD, BUS_RDX).
- Sub-module `rr_arbiter`: combinational round-robin picker.
  - Inputs: request vector and last-grant index.
  - Outputs: one-hot grant and index.
  - It is reused by the future memory-port arbiter.

## Test plan
- Single read: after reset, `req_valid`=0001, `req_write`=0, `snoop_hit`=0100 → `req_ready`=0001 at t+1, `BR`=1110, `BW`=0, then `S[0]`=1 for 4 cycles, `done`=0001 at t+5.
- Write with dirty holder: cache 2 `req_write`=1, `snoop_dirty`=1000 → `BW`=1011 in SNOOP, `flush_sel`=1000 through DATA, `S[2]`=1.
- Fairness: all four caches request continuously → grants in order 0,1,2,3,0, each separated by exactly 6 cycles.
- Error: two non-owners dirty → `protocol_err`=1 and held; `flush_sel` = lowest index.
- Reset mid-DATA (beat 2) → all outputs 0 at once, no `done`. A request pending after reset release is granted starting from cache 0.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared types for the MESI snoop-bus cluster: bus sequencer states,
// line-state encodings used by mesi_fsm, and bus operation codes.
package mesi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DATA  = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_t;

    typedef enum logic {
        BUS_RD  = 1'b0,
        BUS_RDX = 1'b1
    } bus_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at the index just
// after lastIdx and wraps, so the most recent winner has lowest priority.
// Kept generic so the memory-port arbiter can reuse it.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] lastIdx,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grantIdx
);

    localparam int IDX_W = $clog2(N);

    // Walk the requesters in rotating order and keep the first one found.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] candIdx;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        candIdx  = '0;
        for (int off = 1; off <= N; off++) begin
            candIdx = IDX_W'((int'(lastIdx) + off) % N);
            if (!found && req[candIdx]) begin
                found           = 1'b1;
                grant[candIdx]  = 1'b1;
                grantIdx        = candIdx;
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snoop-bus arbiter and transaction sequencer. Grants one cache at a time
// in round-robin order, strobes BR/BW to every other cache for one snoop
// cycle, then holds the shared/flush result for the data phase. Every
// output is registered; the *_d values are the next-cycle outputs.
module mesi_bus_arbiter #(
    parameter int N_CACHES   = 4,
    parameter int DATA_BEATS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CACHES-1:0]         req_valid,
    input  logic [N_CACHES-1:0]         req_write,
    output logic [N_CACHES-1:0]         req_ready,
    input  logic [N_CACHES-1:0]         snoop_hit,
    input  logic [N_CACHES-1:0]         snoop_dirty,
    output logic [N_CACHES-1:0]         BR,
    output logic [N_CACHES-1:0]         BW,
    output logic [N_CACHES-1:0]         S,
    output logic [N_CACHES-1:0]         flush_sel,
    output logic [N_CACHES-1:0]         done,
    output logic                        bus_busy,
    output logic [$clog2(N_CACHES)-1:0] owner,
    output logic                        protocol_err
);

    import mesi_pkg::*;

    localparam int IDX_W  = $clog2(N_CACHES);
    localparam int BEAT_W = $clog2(DATA_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

    bus_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    lastOwner_q, lastOwner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic [N_CACHES-1:0] reqReady_q, reqReady_d;
    logic [N_CACHES-1:0] br_q, br_d;
    logic [N_CACHES-1:0] bw_q, bw_d;
    logic [N_CACHES-1:0] s_q, s_d;
    logic [N_CACHES-1:0] flushSel_q, flushSel_d;
    logic [N_CACHES-1:0] done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [N_CACHES-1:0] grantOneHot;
    logic [IDX_W-1:0]    grantIdx;
    logic                anyReq;
    bus_op_t             reqOp;
    logic [N_CACHES-1:0] ownerOneHot;
    logic [N_CACHES-1:0] hitMasked;
    logic [N_CACHES-1:0] dirtyMasked;
    logic [N_CACHES-1:0] dirtyLowest;
    logic                multiDirty;

    rr_arbiter #(
        .N (N_CACHES)
    ) uPicker (
        .req      (req_valid),
        .lastIdx  (lastOwner_q),
        .grant    (grantOneHot),
        .grantIdx (grantIdx)
    );

    assign anyReq      = |req_valid;
    assign reqOp       = req_write[grantIdx] ? BUS_RDX : BUS_RD;
    assign ownerOneHot = N_CACHES'(1) << owner_q;
    assign hitMasked   = snoop_hit & ~ownerOneHot;
    assign dirtyMasked = snoop_dirty & ~ownerOneHot;
    assign dirtyLowest = dirtyMasked & (~dirtyMasked + N_CACHES'(1));
    assign multiDirty  = (dirtyMasked & (dirtyMasked - N_CACHES'(1))) != '0;

    // State, bookkeeping and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= IDX_W'(N_CACHES - 1);
            beat_q      <= '0;
            reqReady_q  <= '0;
            br_q        <= '0;
            bw_q        <= '0;
            s_q         <= '0;
            flushSel_q  <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            beat_q      <= beat_d;
            reqReady_q  <= reqReady_d;
            br_q        <= br_d;
            bw_q        <= bw_d;
            s_q         <= s_d;
            flushSel_q  <= flushSel_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Sequencer: IDLE picks a winner, SNOOP lasts one cycle, DATA counts beats.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        beat_d      = beat_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d     = SNOOP;
                    owner_d     = grantIdx;
                    lastOwner_d = grantIdx;
                end
            end
            SNOOP: begin
                state_d = DATA;
                beat_d  = '0;
            end
            DATA: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next-cycle output values, computed one cycle early so outputs are flops.
    always_comb begin
        reqReady_d = '0;
        br_d       = '0;
        bw_d       = '0;
        s_d        = '0;
        flushSel_d = '0;
        done_d     = '0;
        busy_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    reqReady_d = grantOneHot;
                    busy_d     = 1'b1;
                    if (reqOp == BUS_RDX) begin
                        bw_d = ~grantOneHot;
                    end else begin
                        br_d = ~grantOneHot;
                    end
                end
            end
            SNOOP: begin
                busy_d         = 1'b1;
                s_d[owner_q]   = |hitMasked;
                flushSel_d     = dirtyLowest;
                if (LAST_BEAT == '0) begin
                    done_d = ownerOneHot;
                end
                if (multiDirty || !req_valid[owner_q]) begin
                    err_d = 1'b1;
                end
            end
            DATA: begin
                if (beat_q != LAST_BEAT) begin
                    busy_d     = 1'b1;
                    s_d        = s_q;
                    flushSel_d = flushSel_q;
                    if (beat_q + BEAT_W'(1) == LAST_BEAT) begin
                        done_d = ownerOneHot;
                    end
                end
            end
            default: ;
        endcase
    end

    assign req_ready    = reqReady_q;
    assign BR           = br_q;
    assign BW           = bw_q;
    assign S            = s_q;
    assign flush_sel    = flushSel_q;
    assign done         = done_q;
    assign bus_busy     = busy_q;
    assign owner        = owner_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter. Expected transactions are pushed to
// a scoreboard when requests are driven and popped when a grant appears.
module tb_mesi_bus_arbiter;

    localparam int N     = 4;
    localparam int BEATS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_write;
    logic [3:0] snoop_hit;
    logic [3:0] snoop_dirty;
    logic [3:0] req_ready;
    logic [3:0] BR;
    logic [3:0] BW;
    logic [3:0] S;
    logic [3:0] flush_sel;
    logic [3:0] done;
    logic       bus_busy;
    logic [1:0] owner;
    logic       protocol_err;

    typedef struct {
        int         owner;
        logic [3:0] ready;
        logic [3:0] br;
        logic [3:0] bw;
        logic [3:0] s;
        logic [3:0] flush;
        logic       err;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   modelLast   = N - 1;
    logic modelErr    = 1'b0;
    int   cycleCount  = 0;

    mesi_bus_arbiter #(
        .N_CACHES   (N),
        .DATA_BEATS (BEATS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_ready    (req_ready),
        .snoop_hit    (snoop_hit),
        .snoop_dirty  (snoop_dirty),
        .BR           (BR),
        .BW           (BW),
        .S            (S),
        .flush_sel    (flush_sel),
        .done         (done),
        .bus_busy     (bus_busy),
        .owner        (owner),
        .protocol_err (protocol_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between grants.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int predictWinner(input logic [3:0] valid, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic pushExpect(input int own, input logic isWrite, input logic [3:0] hit, input logic [3:0] dirty);
        exp_t       e;
        logic [3:0] others;
        int         nDirty;
        e.owner      = own;
        e.ready      = 4'b0000;
        e.ready[own] = 1'b1;
        others       = ~e.ready;
        e.br         = isWrite ? 4'b0000 : others;
        e.bw         = isWrite ? others : 4'b0000;
        e.s          = 4'b0000;
        e.s[own]     = |(hit & others);
        e.flush      = 4'b0000;
        nDirty       = 0;
        for (int i = 0; i < N; i++) begin
            if (dirty[i] && others[i]) begin
                if (nDirty == 0) e.flush[i] = 1'b1;
                nDirty++;
            end
        end
        if (nDirty > 1) modelErr = 1'b1;
        e.err     = modelErr;
        modelLast = own;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] write,
                                 input logic [3:0] hit, input logic [3:0] dirty);
        int w;
        req_valid   = valid;
        req_write   = write;
        snoop_hit   = hit;
        snoop_dirty = dirty;
        w = predictWinner(valid, modelLast);
        if (w >= 0) pushExpect(w, write[w], hit, dirty);
    endtask

    // Waits for a grant, checks SNOOP then DATA beats then the IDLE gap.
    // abortBeat >= 0 returns at that DATA beat's sample point without checking it.
    task automatic runTransaction(input string name, input bit releaseReq, input int abortBeat,
                                  output int grantCycle);
        exp_t e;
        int   waitCnt;
        grantCycle = -1;
        waitCnt    = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (req_ready === 4'b0000 && waitCnt < 20);
        if (req_ready === 4'b0000 || expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s.grant: observed ready 0x%0h queued %0d required a grant", name, req_ready, expQ.size());
            return;
        end
        e          = expQ.pop_front();
        grantCycle = cycleCount;
        checkOutput({name, ".ready"}, 32'(req_ready), 32'(e.ready));
        checkOutput({name, ".BR"},    32'(BR),        32'(e.br));
        checkOutput({name, ".BW"},    32'(BW),        32'(e.bw));
        checkOutput({name, ".owner"}, 32'(owner),     32'(e.owner));
        checkOutput({name, ".busyS"}, 32'(bus_busy),  32'd1);
        for (int beat = 0; beat < BEATS; beat++) begin
            logic [3:0] expDone;
            @(negedge clk);
            if (beat == 0 && releaseReq) begin
                req_valid[e.owner] = 1'b0;
                req_write[e.owner] = 1'b0;
            end
            if (beat == abortBeat) return;
            expDone = (beat == BEATS - 1) ? e.ready : 4'b0000;
            checkOutput($sformatf("%s.S.b%0d", name, beat),     32'(S),            32'(e.s));
            checkOutput($sformatf("%s.flush.b%0d", name, beat), 32'(flush_sel),    32'(e.flush));
            checkOutput($sformatf("%s.done.b%0d", name, beat),  32'(done),         32'(expDone));
            checkOutput($sformatf("%s.busy.b%0d", name, beat),  32'(bus_busy),     32'd1);
            checkOutput($sformatf("%s.rdy.b%0d", name, beat),   32'(req_ready | BR | BW), 32'd0);
            checkOutput($sformatf("%s.err.b%0d", name, beat),   32'(protocol_err), 32'(e.err));
        end
        @(negedge clk);
        checkOutput({name, ".idleBusy"}, 32'(bus_busy),  32'd0);
        checkOutput({name, ".idleDone"}, 32'(done),      32'd0);
        checkOutput({name, ".idleS"},    32'(S | flush_sel), 32'd0);
    endtask

    // Directed sequence: reset, read, write with flush, fairness, error, abort.
    initial begin
        int gc;
        int prevGc;
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        snoop_hit   = '0;
        snoop_dirty = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.ready", 32'(req_ready),    32'd0);
        checkOutput("reset.busy",  32'(bus_busy),     32'd0);
        checkOutput("reset.owner", 32'(owner),        32'd0);
        checkOutput("reset.err",   32'(protocol_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single read from cache 0");
        applyStimulus(4'b0001, 4'b0000, 4'b0100, 4'b0000);
        runTransaction("read0", 1'b1, -1, gc);

        $display("[TB] write from cache 2 with dirty holder 3");
        applyStimulus(4'b0100, 4'b0100, 4'b1000, 4'b1100);
        runTransaction("write2", 1'b1, -1, gc);

        reset = 1'b1;
        modelLast = N - 1;
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] fairness with all caches requesting");
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 1; i < 5; i++) begin
            pushExpect(predictWinner(4'b1111, modelLast), 1'b0, 4'b0000, 4'b0000);
        end
        prevGc = 0;
        for (int i = 0; i < 5; i++) begin
            runTransaction($sformatf("fair%0d", i), 1'b0, -1, gc);
            if (i > 0) checkOutput($sformatf("fair.gap%0d", i), 32'(gc - prevGc), 32'd6);
            prevGc = gc;
        end
        req_valid = '0;

        $display("[TB] two dirty non-owners");
        applyStimulus(4'b0010, 4'b0000, 4'b1100, 4'b1100);
        runTransaction("err1", 1'b1, -1, gc);
        repeat (3) @(negedge clk);
        checkOutput("err.sticky", 32'(protocol_err), 32'd1);

        $display("[TB] reset during data beat 2");
        applyStimulus(4'b0010, 4'b0000, 4'b0001, 4'b0000);
        runTransaction("abort", 1'b1, 2, gc);
        reset = 1'b1;
        modelLast = N - 1;
        modelErr  = 1'b0;
        #1;
        checkOutput("abort.ready", 32'(req_ready),    32'd0);
        checkOutput("abort.BRBW",  32'(BR | BW),      32'd0);
        checkOutput("abort.S",     32'(S),            32'd0);
        checkOutput("abort.flush", 32'(flush_sel),    32'd0);
        checkOutput("abort.done",  32'(done),         32'd0);
        checkOutput("abort.busy",  32'(bus_busy),     32'd0);
        checkOutput("abort.owner", 32'(owner),        32'd0);
        checkOutput("abort.err",   32'(protocol_err), 32'd0);
        @(negedge clk);
        checkOutput("abort.doneHeld", 32'(done), 32'd0);
        reset = 1'b0;
        applyStimulus(4'b0101, 4'b0000, 4'b0000, 4'b0000);
        runTransaction("postReset", 1'b1, -1, gc);
        req_valid = '0;
        repeat (2) @(negedge clk);
        checkOutput("final.queueEmpty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
